// File: rtl/btn_arb_pkg.sv
// rtl/btn_arb_pkg.sv - shared state encoding, limits and width helper for the button event arbiter
package btn_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int N_BTN_MAX = 16;

    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// rtl/btn_event_arbiter_rr_pick.sv - combinational round-robin first-set finder (module rr_pick)
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    int  idx;
    logic found;

    // Scan starts just after the last winner so it gets lowest priority.
    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = W'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - round-robin arbiter of per-button press pulses onto one valid/ready event channel
// Optional saturating drop counter enabled by `BTN_ARB_DROP_CNT_EN.
module btn_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int  N_BTN  = 4,
    parameter int  DROP_W = 8,
    localparam int IDW    = idw_of(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pulse_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDW-1:0]   ev_id,
    output logic [N_BTN-1:0] pend,
    output logic             overrun,
    input  logic             clr_overrun
`ifdef BTN_ARB_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    if (N_BTN < 2 || N_BTN > N_BTN_MAX || DROP_W < 1) begin : g_bad_cfg
        $error("btn_event_arbiter: unsupported N_BTN or DROP_W");
    end

    state_t           state, state_nxt;
    logic [IDW-1:0]   last, last_nxt;
    logic [IDW-1:0]   ev_id_nxt;
    logic [IDW-1:0]   pick;
    logic             pick_any;
    logic             grant;
    logic [N_BTN-1:0] gnt_mask;
    logic             drop;

    rr_pick #(
        .N (N_BTN),
        .W (IDW)
    ) u_rr_pick (
        .req    (pend),
        .last   (last),
        .gnt_id (pick),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= IDW'(N_BTN - 1);
            ev_id <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            ev_id <= ev_id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        ev_id_nxt = ev_id;
        grant     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant     = 1'b1;
                    ev_id_nxt = pick;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ev_ready) begin
                    last_nxt  = ev_id;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ev_valid = (state == ST_HOLD);

    // A pulse landing on its own grant cycle re-arms the latch rather than counting as a drop.
    always_comb begin
        gnt_mask = '0;
        if (grant) begin
            gnt_mask[pick] = 1'b1;
        end
    end

    assign drop = |(pulse_in & pend & ~gnt_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            pend <= (pend & ~gnt_mask) | pulse_in;
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef BTN_ARB_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_overrun) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (clr_overrun) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - scoreboard bench for btn_event_arbiter against a behavioural model
module tb_btn_event_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CNT_MAX = (1 << DW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pulse_in;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_id;
    logic [N-1:0] pend;
    logic         overrun;
    logic         clr_overrun;
`ifdef BTN_ARB_DROP_CNT_EN
    logic [DW-1:0] drop_cnt;
`endif

    btn_event_arbiter #(.N_BTN(N), .DROP_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_id       (ev_id),
        .pend        (pend),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef BTN_ARB_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    // Behavioural model: set of pending buttons, one in-flight event, last winner.
    bit m_pend[N];
    bit m_busy;
    int m_cur;
    int m_last;
    bit m_ovr;
    int m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_busy = 1'b0;
        m_cur  = 0;
        m_last = N - 1;
        m_ovr  = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [N-1:0] p, input bit r, input bit c);
        int g;
        bit dropped;
        g = -1;
        dropped = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (g < 0 && m_pend[i]) g = i;
            end
        end
        for (int i = 0; i < N; i++) if (p[i] && m_pend[i] && i != g) dropped = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == g) m_pend[i] = 1'b0;
            if (p[i]) m_pend[i] = 1'b1;
        end
        if (dropped) begin
            m_ovr = 1'b1;
            m_cnt = c ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
        end else if (c) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        if (g >= 0) begin
            m_busy = 1'b1;
            m_cur  = g;
            exp_q.push_back(g);
        end else if (m_busy && r) begin
            m_busy = 1'b0;
            m_last = m_cur;
        end
    endtask

    task automatic check_state(input string tag);
        int mp;
        mp = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) mp |= (1 << i);
        chk({tag, ".ev_valid"}, int'(ev_valid), int'(m_busy));
        if (m_busy) chk({tag, ".ev_id_hold"}, int'(ev_id), m_cur);
        chk({tag, ".pend"}, int'(pend), mp);
        chk({tag, ".overrun"}, int'(overrun), int'(m_ovr));
`ifdef BTN_ARB_DROP_CNT_EN
        chk({tag, ".drop_cnt"}, int'(drop_cnt), m_cnt);
`endif
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input string tag, input logic [N-1:0] p, input bit r, input bit c);
        pulse_in    = p;
        ev_ready    = r;
        clr_overrun = c;
        model_step(p, r, c);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb.unexpected_event", int'(ev_id), -1);
            end else begin
                chk("sb.ev_id", int'(ev_id), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        pulse_in = '0;
        ev_ready = 1'b0;
        clr_overrun = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ev_valid", int'(ev_valid), 0);
        chk("rst.ev_id", int'(ev_id), 0);
        chk("rst.pend", int'(pend), 0);
        chk("rst.overrun", int'(overrun), 0);
        rst = 1'b0;

        // T1: reset mid-HOLD with pend=0110 and overrun set
        cycle("t1a", 4'b0111, 1'b0, 1'b0);
        cycle("t1b", 4'b0000, 1'b0, 1'b0);
        cycle("t1c", 4'b0010, 1'b0, 1'b0);
        chk("t1.pre_pend", int'(pend), 4'b0110);
        #2 rst = 1'b1;
        #1;
        chk("t1.rst_ev_valid", int'(ev_valid), 0);
        chk("t1.rst_pend", int'(pend), 0);
        chk("t1.rst_overrun", int'(overrun), 0);
        pulse_in = '0;
        ev_ready = 1'b0;
        clr_overrun = 1'b0;
        rst = 1'b0;
        model_reset();
        cycle("t1d", 4'b0000, 1'b0, 1'b0);
        cycle("t1e", 4'b0001, 1'b1, 1'b0);
        repeat (3) cycle("t1f", 4'b0000, 1'b1, 1'b0);

        // T2: single pulse latency
        cycle("t2a", 4'b0100, 1'b1, 1'b0);
        chk("t2.no_valid_yet", int'(ev_valid), 0);
        cycle("t2b", 4'b0000, 1'b1, 1'b0);
        chk("t2.valid", int'(ev_valid), 1);
        chk("t2.id", int'(ev_id), 2);
        chk("t2.pend_clear", int'(pend), 0);
        repeat (2) cycle("t2c", 4'b0000, 1'b1, 1'b0);

        // T3: all buttons at once
        cycle("t3a", 4'b1111, 1'b1, 1'b0);
        repeat (10) cycle("t3b", 4'b0000, 1'b1, 1'b0);
        chk("t3.no_overrun", int'(overrun), 0);

        // T4: backpressure while id=1 granted, pend=0101 behind it
        cycle("t4a", 4'b0010, 1'b0, 1'b0);
        cycle("t4b", 4'b0101, 1'b0, 1'b0);
        repeat (10) cycle("t4c", 4'b0000, 1'b0, 1'b0);
        chk("t4.hold_id", int'(ev_id), 1);
        chk("t4.hold_pend", int'(pend), 4'b0101);
        repeat (6) cycle("t4d", 4'b0000, 1'b1, 1'b0);

        // T5: overrun on button 3 while it waits behind button 0
        cycle("t5a", 4'b0001, 1'b0, 1'b0);
        cycle("t5b", 4'b1000, 1'b0, 1'b0);
        cycle("t5c", 4'b1000, 1'b0, 1'b0);
        chk("t5.overrun", int'(overrun), 1);
        repeat (6) cycle("t5d", 4'b0000, 1'b1, 1'b0);
        cycle("t5e", 4'b0000, 1'b1, 1'b1);
        chk("t5.cleared", int'(overrun), 0);

        // T6: pulse on the grant cycle of the same button
        cycle("t6a", 4'b0001, 1'b0, 1'b0);
        cycle("t6b", 4'b0001, 1'b0, 1'b0);
        chk("t6.pend0", int'(pend[0]), 1);
        chk("t6.no_overrun", int'(overrun), 0);
        repeat (6) cycle("t6c", 4'b0000, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] p;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 5) == 0);
            cycle("rnd", p, ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end

        repeat (20) cycle("drain", 4'b0000, 1'b1, 1'b0);
        chk("drain.queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
